// File: rtl/flash_audio_pkg.sv
// Shared types and constants for the flash audio fetch stage.
// Word and sample widths, default song bounds, FSM states and the LED magnitude helper.
package flash_audio_pkg;

  localparam int WORD_W     = 32;
  localparam int SAMPLE_W   = 16;
  localparam int MAG_W      = 8;
  localparam int DEF_ADDR_W = 23;

  localparam logic [DEF_ADDR_W-1:0] DEF_START_ADDR = 23'h0;
  localparam logic [DEF_ADDR_W-1:0] DEF_END_ADDR   = 23'h7FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_DATA,
    ST_EMIT_A,
    ST_WAIT_TICK,
    ST_EMIT_B
  } state_t;

  // |s[15:8]| as unsigned; -128 becomes 8'h80 through two's-complement wrap.
  function automatic logic [MAG_W-1:0] mag_of(input logic [SAMPLE_W-1:0] s);
    logic [MAG_W-1:0] hi;
    hi = s[SAMPLE_W-1 -: MAG_W];
    return hi[MAG_W-1] ? (~hi + 8'd1) : hi;
  endfunction

endpackage

// File: rtl/flash_audio_reader.sv
// Fetches 32-bit words from flash over Avalon-MM and plays them as two signed
// 16-bit samples, one per sample_tick, with an LED magnitude and finish strobe.
module flash_audio_reader
  import flash_audio_pkg::*;
#(
  parameter int                 ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0]  START_ADDR = ADDR_W'(DEF_START_ADDR),
  parameter logic [ADDR_W-1:0]  END_ADDR   = ADDR_W'(DEF_END_ADDR)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sample_tick,
  input  logic                 play,
  input  logic                 direction,
  input  logic                 restart,
  output logic                 flash_read,
  output logic [ADDR_W-1:0]    flash_address,
  input  logic                 flash_waitrequest,
  input  logic [WORD_W-1:0]    flash_readdata,
  input  logic                 flash_readdatavalid,
  output logic [SAMPLE_W-1:0]  audio_data,
  output logic [MAG_W-1:0]     sample_mag,
  output logic                 finish
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [SAMPLE_W-1:0] audio_q, audio_d;
  logic [MAG_W-1:0]    mag_q, mag_d;
  logic                fin_q, fin_d;
  logic                read_q, read_d;
  logic                pend_q, pend_d;
  logic                rev_q, rev_d;

  logic                adv;
  logic [ADDR_W-1:0]   restart_addr;
  logic [ADDR_W-1:0]   step_addr;

  assign adv          = sample_tick & play;
  assign restart_addr = direction ? END_ADDR : START_ADDR;

  always_comb begin
    step_addr = addr_q;
    if (direction) step_addr = (addr_q == START_ADDR) ? END_ADDR : addr_q - 1'b1;
    else           step_addr = (addr_q == END_ADDR) ? START_ADDR : addr_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    audio_d = audio_q;
    fin_d   = 1'b0;
    read_d  = read_q;
    pend_d  = pend_q;
    rev_d   = rev_q;

    // Outside IDLE a restart is only remembered; the fetch in flight completes.
    if (restart && state_q != ST_IDLE) pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (restart) addr_d = restart_addr;
        if (adv) begin
          state_d = ST_REQ;
          read_d  = 1'b1;
        end
      end
      ST_REQ: begin
        if (!flash_waitrequest) begin
          state_d = ST_WAIT_DATA;
          read_d  = 1'b0;
        end
      end
      ST_WAIT_DATA: begin
        if (flash_readdatavalid) begin
          word_d  = flash_readdata;
          state_d = ST_EMIT_A;
        end
      end
      ST_EMIT_A: begin
        rev_d   = direction;
        audio_d = direction ? word_q[WORD_W-1 -: SAMPLE_W] : word_q[SAMPLE_W-1:0];
        fin_d   = 1'b1;
        state_d = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (adv) state_d = ST_EMIT_B;
      end
      ST_EMIT_B: begin
        // Emit whichever half EMIT_A skipped, even if direction flipped since.
        audio_d = rev_q ? word_q[SAMPLE_W-1:0] : word_q[WORD_W-1 -: SAMPLE_W];
        fin_d   = 1'b1;
        addr_d  = (pend_q || restart) ? restart_addr : step_addr;
        pend_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        read_d  = 1'b0;
      end
    endcase

    mag_d = mag_of(audio_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= START_ADDR;
      word_q  <= '0;
      audio_q <= '0;
      mag_q   <= '0;
      fin_q   <= 1'b0;
      read_q  <= 1'b0;
      pend_q  <= 1'b0;
      rev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      audio_q <= audio_d;
      mag_q   <= mag_d;
      fin_q   <= fin_d;
      read_q  <= read_d;
      pend_q  <= pend_d;
      rev_q   <= rev_d;
    end
  end

  assign flash_read    = read_q;
  assign flash_address = addr_q;
  assign audio_data    = audio_q;
  assign sample_mag    = mag_q;
  assign finish        = fin_q;

endmodule
